// File: rtl/bus_bridge_pkg.sv
// Shared constants and helpers for the data-side bus bridge:
// peripheral address map, bus target selection and 7-segment decoding.
package bus_bridge_pkg;

    localparam logic [19:0] PERIPH_BASE_HI = 20'hFFFFF;

    localparam logic [11:0] OFF_TUBE = 12'h000;
    localparam logic [11:0] OFF_LED  = 12'h060;
    localparam logic [11:0] OFF_SW   = 12'h070;
    localparam logic [11:0] OFF_BTN  = 12'h078;

    typedef enum logic [2:0] {
        SEL_DRAM,
        SEL_TUBE,
        SEL_LED,
        SEL_SW,
        SEL_BTN,
        SEL_NONE
    } bus_sel_e;

    // Active-low segments, bit 0 = A ... bit 6 = G.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bus_bridge_seg7_scan.sv
// Time-multiplexed scan of the eight 7-segment digits. Each digit is held
// for SCAN_DIV clocks; digit enables and segments are registered.
module seg7_scan
    import bus_bridge_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] tube_reg,
    output logic [7:0]  dig_en,
    output logic [7:0]  seg
);

    localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [3:0]       nibble;

    always_comb begin
        nibble = tube_reg[{idx, 2'b00} +: 4];
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            cnt    <= '0;
            idx    <= '0;
            dig_en <= '1;
            seg    <= '1;
        end else begin
            if (cnt == CNT_MAX) begin
                cnt <= '0;
                idx <= idx + 3'd1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            // Outputs follow idx one clock later; DP is held off.
            dig_en <= ~(8'd1 << idx);
            seg    <= {1'b1, hex_to_seg(nibble)};
        end
    end

endmodule

// File: rtl/bus_bridge.sv
// Data-side bus bridge: splits the core's bus between data RAM and the
// memory-mapped TUBE/LED/SW/BTN peripherals. Reads are combinational.
module bus_bridge
    import bus_bridge_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DRAM_AW  = 14
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    input  logic [31:0]        Bus_addr,
    output logic [31:0]        Bus_rdata,
    input  logic               Bus_wen,
    input  logic [31:0]        Bus_wdata,
    output logic [DRAM_AW-1:0] dram_addr,
    input  logic [31:0]        dram_rdata,
    output logic               dram_we,
    output logic [31:0]        dram_wdata,
    input  logic [23:0]        sw,
    input  logic [4:0]         button,
    output logic [23:0]        led,
    output logic [7:0]         dig_en,
    output logic [7:0]         seg
);

    logic        hit;
    bus_sel_e    sel;
    logic [31:0] tube_reg;
    logic [23:0] led_reg;
    logic [23:0] sw_s1, sw_s2;
    logic [4:0]  btn_s1, btn_s2;

    always_comb begin
        hit = (Bus_addr[31:12] == PERIPH_BASE_HI);
        sel = SEL_DRAM;
        if (hit) begin
            case (Bus_addr[11:0])
                OFF_TUBE: sel = SEL_TUBE;
                OFF_LED:  sel = SEL_LED;
                OFF_SW:   sel = SEL_SW;
                OFF_BTN:  sel = SEL_BTN;
                default:  sel = SEL_NONE;
            endcase
        end
    end

    assign dram_addr  = Bus_addr[DRAM_AW+1:2];
    assign dram_we    = Bus_wen & ~hit;
    assign dram_wdata = Bus_wdata;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            tube_reg <= '0;
            led_reg  <= '0;
            sw_s1    <= '0;
            sw_s2    <= '0;
            btn_s1   <= '0;
            btn_s2   <= '0;
        end else begin
            sw_s1  <= sw;
            sw_s2  <= sw_s1;
            btn_s1 <= button;
            btn_s2 <= btn_s1;
            if (Bus_wen && sel == SEL_TUBE) tube_reg <= Bus_wdata;
            if (Bus_wen && sel == SEL_LED)  led_reg  <= Bus_wdata[23:0];
        end
    end

    always_comb begin
        Bus_rdata = '0;
        case (sel)
            SEL_DRAM: Bus_rdata = dram_rdata;
            SEL_TUBE: Bus_rdata = tube_reg;
            SEL_LED:  Bus_rdata = {8'b0, led_reg};
            SEL_SW:   Bus_rdata = {8'b0, sw_s2};
            SEL_BTN:  Bus_rdata = {27'b0, btn_s2};
            default:  Bus_rdata = '0;
        endcase
    end

    assign led = led_reg;

    seg7_scan #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scan (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .tube_reg(tube_reg),
        .dig_en  (dig_en),
        .seg     (seg)
    );

endmodule

// File: tb/tb_bus_bridge.sv
// Self-checking bench for bus_bridge: directed scenarios plus randomized
// bus traffic compared against an address-map level reference model.
module tb_bus_bridge;

    localparam int unsigned SD = 4;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic [31:0] Bus_addr;
    logic [31:0] Bus_rdata;
    logic        Bus_wen;
    logic [31:0] Bus_wdata;
    logic [13:0] dram_addr;
    logic [31:0] dram_rdata;
    logic        dram_we;
    logic [31:0] dram_wdata;
    logic [23:0] sw;
    logic [4:0]  button;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  seg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_tube;
    logic [23:0] m_led;
    logic [23:0] m_sw;
    logic [4:0]  m_btn;
    int          scan_n;

    bus_bridge #(
        .SCAN_DIV(SD),
        .DRAM_AW (14)
    ) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst   (cpu_rst),
        .Bus_addr  (Bus_addr),
        .Bus_rdata (Bus_rdata),
        .Bus_wen   (Bus_wen),
        .Bus_wdata (Bus_wdata),
        .dram_addr (dram_addr),
        .dram_rdata(dram_rdata),
        .dram_we   (dram_we),
        .dram_wdata(dram_wdata),
        .sw        (sw),
        .button    (button),
        .led       (led),
        .dig_en    (dig_en),
        .seg       (seg)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Standard active-low 7-segment patterns including DP-off bit.
    function automatic logic [7:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
            4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
            4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
            4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
        endcase
    endfunction

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic idle();
        Bus_wen   = 1'b0;
        Bus_addr  = 32'h0;
        Bus_wdata = 32'h0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        Bus_addr  = a;
        Bus_wen   = 1'b1;
        Bus_wdata = d;
        step();
        if (a == 32'hFFFFF000) m_tube = d;
        if (a == 32'hFFFFF060) m_led  = d[23:0];
        idle();
    endtask

    task automatic test_reset();
        cpu_rst    = 1'b1;
        sw         = '0;
        button     = '0;
        dram_rdata = '0;
        idle();
        repeat (2) step();
        m_tube = '0; m_led = '0; m_sw = '0; m_btn = '0;
        n_checks++; if (led !== 24'h0) begin n_fail++; $display("FAIL reset_led got=%h exp=%h", led, 24'h0); end
        n_checks++; if (dig_en !== 8'hFF) begin n_fail++; $display("FAIL reset_dig_en got=%h exp=%h", dig_en, 8'hFF); end
        n_checks++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL reset_seg got=%h exp=%h", seg, 8'hFF); end
        Bus_addr = 32'hFFFFF060; #1;
        n_checks++; if (Bus_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_led_read got=%h exp=%h", Bus_rdata, 32'h0); end
        Bus_addr = 32'hFFFFF000; #1;
        n_checks++; if (Bus_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_tube_read got=%h exp=%h", Bus_rdata, 32'h0); end
        cpu_rst = 1'b0;
        idle();
        step();
    endtask

    task automatic test_led();
        Bus_addr = 32'hFFFFF060; Bus_wen = 1'b1; Bus_wdata = 32'h00A5A5A5; #1;
        n_checks++; if (dram_we !== 1'b0) begin n_fail++; $display("FAIL led_dram_we got=%b exp=0", dram_we); end
        step();
        m_led = 24'hA5A5A5;
        Bus_wen = 1'b0; #1;
        n_checks++; if (led !== m_led) begin n_fail++; $display("FAIL led_out got=%h exp=%h", led, m_led); end
        n_checks++; if (Bus_rdata !== 32'h00A5A5A5) begin n_fail++; $display("FAIL led_read got=%h exp=%h", Bus_rdata, 32'h00A5A5A5); end
        bus_write(32'hFFFFF060, 32'hFF000000);
        n_checks++; if (led !== 24'h000000) begin n_fail++; $display("FAIL led_upper_drop got=%h exp=%h", led, 24'h0); end
    endtask

    task automatic test_dram();
        Bus_addr = 32'h00000010; Bus_wen = 1'b1; Bus_wdata = 32'hDEADBEEF; #1;
        n_checks++; if (dram_we !== 1'b1) begin n_fail++; $display("FAIL dram_we got=%b exp=1", dram_we); end
        n_checks++; if (dram_addr !== 14'd4) begin n_fail++; $display("FAIL dram_addr got=%h exp=%h", dram_addr, 14'd4); end
        n_checks++; if (dram_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL dram_wdata got=%h exp=%h", dram_wdata, 32'hDEADBEEF); end
        step();
        Bus_wen = 1'b0; dram_rdata = 32'h12345678; #1;
        n_checks++; if (Bus_rdata !== 32'h12345678) begin n_fail++; $display("FAIL dram_read got=%h exp=%h", Bus_rdata, 32'h12345678); end
        bus_write(32'hFFFFF000, 32'hCAFEF00D);
        bus_write(32'hFFFFF060, 32'h00123ABC);
        Bus_addr = 32'hFFFFF004; #1;
        n_checks++; if (Bus_rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_read got=%h exp=%h", Bus_rdata, 32'h0); end
        n_checks++; if (dram_we !== 1'b0) begin n_fail++; $display("FAIL unmapped_dram_we got=%b exp=0", dram_we); end
        bus_write(32'hFFFFF004, 32'hFFFFFFFF);
        n_checks++; if (led !== m_led) begin n_fail++; $display("FAIL unmapped_led got=%h exp=%h", led, m_led); end
        Bus_addr = 32'hFFFFF000; #1;
        n_checks++; if (Bus_rdata !== m_tube) begin n_fail++; $display("FAIL unmapped_tube got=%h exp=%h", Bus_rdata, m_tube); end
    endtask

    task automatic test_sync();
        step();
        sw = 24'h123456; button = 5'b10101;
        for (int e = 0; e < 4; e++) begin
            logic [31:0] exp_sw, exp_btn;
            exp_sw  = (e >= 2) ? 32'h00123456 : 32'h0;
            exp_btn = (e >= 2) ? 32'h00000015 : 32'h0;
            Bus_addr = 32'hFFFFF070; #1;
            n_checks++; if (Bus_rdata !== exp_sw) begin n_fail++; $display("FAIL sync_sw edge=%0d got=%h exp=%h", e, Bus_rdata, exp_sw); end
            Bus_addr = 32'hFFFFF078; #1;
            n_checks++; if (Bus_rdata !== exp_btn) begin n_fail++; $display("FAIL sync_btn edge=%0d got=%h exp=%h", e, Bus_rdata, exp_btn); end
            step();
        end
        m_sw = 24'h123456; m_btn = 5'b10101;
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            int unsigned kind;
            logic [31:0] a, d, rd, exp_rd;
            logic        w, exp_we;
            kind = $urandom_range(0, 5);
            d    = $urandom;
            rd   = $urandom;
            w    = 1'($urandom_range(0, 1));
            case (kind)
                0: a = 32'hFFFFF000;
                1: a = 32'hFFFFF060;
                2: a = 32'hFFFFF070;
                3: a = 32'hFFFFF078;
                4: a = 32'hFFFFF200 + 32'($urandom_range(0, 63)) * 4;
                default: a = $urandom & 32'h0000FFFC;
            endcase
            case (kind)
                0: exp_rd = m_tube;
                1: exp_rd = {8'h0, m_led};
                2: exp_rd = {8'h0, m_sw};
                3: exp_rd = {27'h0, m_btn};
                4: exp_rd = 32'h0;
                default: exp_rd = rd;
            endcase
            exp_we = w && (kind == 5);
            Bus_addr = a; Bus_wen = w; Bus_wdata = d; dram_rdata = rd; #1;
            n_checks++; if (Bus_rdata !== exp_rd) begin n_fail++; $display("FAIL rand_read i=%0d a=%h got=%h exp=%h", i, a, Bus_rdata, exp_rd); end
            n_checks++; if (dram_we !== exp_we) begin n_fail++; $display("FAIL rand_dram_we i=%0d got=%b exp=%b", i, dram_we, exp_we); end
            if (kind == 5) begin
                n_checks++; if (dram_addr !== a[15:2]) begin n_fail++; $display("FAIL rand_dram_addr i=%0d got=%h exp=%h", i, dram_addr, a[15:2]); end
            end
            step();
            if (w && kind == 0) m_tube = d;
            if (w && kind == 1) m_led  = d[23:0];
            n_checks++; if (led !== m_led) begin n_fail++; $display("FAIL rand_led i=%0d got=%h exp=%h", i, led, m_led); end
        end
        idle();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            logic [31:0] a, d, exp_rd;
            a = i[0] ? 32'hFFFFF060 : 32'hFFFFF000;
            d = $urandom;
            exp_rd = i[0] ? {8'h0, m_led} : m_tube;
            Bus_addr = a; Bus_wen = 1'b1; Bus_wdata = d; #1;
            n_checks++; if (Bus_rdata !== exp_rd) begin n_fail++; $display("FAIL b2b_read i=%0d got=%h exp=%h", i, Bus_rdata, exp_rd); end
            step();
            if (i[0]) m_led = d[23:0]; else m_tube = d;
        end
        idle();
        Bus_addr = 32'hFFFFF000; #1;
        n_checks++; if (Bus_rdata !== m_tube) begin n_fail++; $display("FAIL b2b_tube got=%h exp=%h", Bus_rdata, m_tube); end
        n_checks++; if (led !== m_led) begin n_fail++; $display("FAIL b2b_led got=%h exp=%h", led, m_led); end
    endtask

    // Register outputs after the n-th edge since reset release show digit
    // (n-1)/SD using the tube value held before that edge.
    task automatic scan_check(input logic [31:0] tube_before);
        int d;
        logic [7:0] exp_dig, exp_seg;
        logic [31:0] t;
        d = ((scan_n - 1) / SD) % 8;
        t = tube_before >> (4 * d);
        exp_dig = ~(8'h01 << d);
        exp_seg = seg_of(t[3:0]);
        n_checks++; if (dig_en !== exp_dig) begin n_fail++; $display("FAIL scan_dig n=%0d got=%h exp=%h", scan_n, dig_en, exp_dig); end
        n_checks++; if (seg !== exp_seg) begin n_fail++; $display("FAIL scan_seg n=%0d got=%h exp=%h", scan_n, seg, exp_seg); end
    endtask

    task automatic test_scan();
        logic [31:0] prev;
        cpu_rst = 1'b1; idle();
        step();
        cpu_rst = 1'b0;
        m_tube = '0; m_led = '0;
        prev = m_tube;
        Bus_addr = 32'hFFFFF000; Bus_wen = 1'b1; Bus_wdata = 32'h876543F0;
        step();
        scan_n = 1;
        m_tube = 32'h876543F0;
        idle();
        scan_check(prev);
        while (scan_n < 72) begin
            step();
            scan_n++;
            scan_check(m_tube);
        end
    endtask

    task automatic test_reset_mid_scan();
        while (((scan_n / SD) % 8) != 5) begin
            step();
            scan_n++;
            scan_check(m_tube);
        end
        cpu_rst = 1'b1;
        Bus_addr = 32'hFFFFF000; Bus_wen = 1'b1; Bus_wdata = 32'h12345678;
        step();
        m_tube = '0; m_led = '0;
        Bus_wen = 1'b0; #1;
        n_checks++; if (Bus_rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_tube got=%h exp=%h", Bus_rdata, 32'h0); end
        n_checks++; if (dig_en !== 8'hFF) begin n_fail++; $display("FAIL midrst_dig got=%h exp=%h", dig_en, 8'hFF); end
        n_checks++; if (seg !== 8'hFF) begin n_fail++; $display("FAIL midrst_seg got=%h exp=%h", seg, 8'hFF); end
        step();
        n_checks++; if (dig_en !== 8'hFF) begin n_fail++; $display("FAIL midrst_hold_dig got=%h exp=%h", dig_en, 8'hFF); end
        cpu_rst = 1'b0; idle();
        step();
        n_checks++; if (dig_en !== 8'hFE) begin n_fail++; $display("FAIL midrst_first_dig got=%h exp=%h", dig_en, 8'hFE); end
        n_checks++; if (seg !== 8'hC0) begin n_fail++; $display("FAIL midrst_first_seg got=%h exp=%h", seg, 8'hC0); end
        repeat (SD) step();
        n_checks++; if (dig_en !== 8'hFD) begin n_fail++; $display("FAIL midrst_second_dig got=%h exp=%h", dig_en, 8'hFD); end
        Bus_addr = 32'hFFFFF000; #1;
        n_checks++; if (Bus_rdata !== m_tube) begin n_fail++; $display("FAIL midrst_tube_after got=%h exp=%h", Bus_rdata, m_tube); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_led();
        test_dram();
        test_sync();
        test_random();
        test_back_to_back();
        test_scan();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_bridge.md
Name: bus_bridge

Overview:
- Data-side bridge directly downstream of the single-cycle CPU core's Bus_* interface.
- Decodes each bus address to either the data RAM or a small set of memory-mapped peripherals: 7-segment display, LEDs, switches and buttons.
- Reads are combinational, because the core writes load data back in the same cycle. Writes are registered.
- Contains the 7-segment scan engine and the input synchronizers.

Parameters:
- SCAN_DIV, 50000: cpu_clk cycles each digit is held during display scanning (must be >= 2).
- DRAM_AW, 14: data RAM word-address width (64 KB).

Ports:
- cpu_clk  in  1  system clock; all state updates on the rising edge.
- cpu_rst  in  1  synchronous, active-high reset.
- Bus_addr  in  32  byte address from the core.
- Bus_rdata  out  32  read data to the core (combinational).
- Bus_wen  in  1  write enable from the core.
- Bus_wdata  in  32  write data from the core.
- dram_addr  out  DRAM_AW  word address to data RAM, = Bus_addr[DRAM_AW+1:2].
- dram_rdata  in  32  data RAM asynchronous read data.
- dram_we  out  1  data RAM write enable.
- dram_wdata  out  32  data RAM write data, = Bus_wdata.
- sw  in  24  board switches (asynchronous).
- button  in  5  board buttons (asynchronous).
- led  out  24  LED drive, active-high.
- dig_en  out  8  digit enables, active-low, one-hot-low.
- seg  out  8  segments, active-low: seg[0]=A … seg[6]=G, seg[7]=DP.

Behaviour:
- Peripheral hit when Bus_addr[31:12] == 20'hFFFFF. Offset is Bus_addr[11:0]:
  - 0x000 TUBE (R/W, 32 bits)
  - 0x060 LED (R/W, low 24 bits)
  - 0x070 SW (R/O)
  - 0x078 BTN (R/O)
- Any other peripheral offset: read returns 0, write ignored. Any non-hit address goes to DRAM.
- dram_we = Bus_wen & ~hit (combinational). Peripheral writes never reach DRAM.
- Bus_rdata is a combinational mux, zero added cycles:
  - DRAM → dram_rdata
  - TUBE → tube_reg
  - LED → {8'b0, led_reg}
  - SW → {8'b0, sw_s2}
  - BTN → {27'b0, btn_s2}
- Writes:
  - TUBE/LED registers load Bus_wdata on the rising edge when Bus_wen and the address matches. Upper 8 bits of LED writes are dropped.
  - A read of the same address in the next cycle returns the new value.
  - led = led_reg, direct.
- Synchronizers: sw and button each pass through two flops (s1→s2). An input change is visible to reads on the 2nd edge after it is stable.
- Scan engine:
  - cnt counts 0..SCAN_DIV-1 and wraps.
  - At cnt == SCAN_DIV-1, idx (3 bits) increments, wrapping 7→0.
  - dig_en and seg are registered from idx and tube_reg[4*idx+3:4*idx], so they update one cycle after idx changes.
  - dig_en = ~(1<<idx).
  - seg[6:0] = hex decode of the nibble; seg[7] = 1 (DP off).
  - Required decode values include: 0→C0, 1→F9, 8→80, A→88, F→8E.
  - A TUBE write takes effect on the next seg register update. No tearing within a digit beyond one cycle.
- Reset values (after the edge with cpu_rst = 1):
  - tube_reg = 0, led_reg = 0, all sync flops = 0
  - cnt = 0, idx = 0
  - dig_en = 8'hFF, seg = 8'hFF
- Reset mid-operation:
  - Reset wins over a simultaneous write. That write is lost.
  - Scanning restarts at digit 0, SCAN_DIV cycles after release.
  - The first enabled digit appears one cycle after release (idx = 0).
- Bus_wen with Bus_addr changing every cycle: one write per edge, no buffering, no stalls. The bridge never back-pressures the core.

Decomposition:
- Shared package holds:
  - address constants: PERIPH_BASE_HI = 20'hFFFFF; OFF_TUBE, OFF_LED, OFF_SW, OFF_BTN
  - the 4-bit→7-bit hex-to-segment decode function
- One sub-module: seg7_scan. Contains cnt, idx, the dig_en/seg registers and the decode. Inputs are cpu_clk, cpu_rst and tube_reg; parameter is SCAN_DIV.
- Address decode, registers and synchronizers stay in bus_bridge.

Test Plan:
- Reset: hold cpu_rst for 2 cycles → led = 0, dig_en = FF, seg = FF, and a read of FFFFF060 returns 0.
- LED write: write 00A5A5A5 to FFFFF060 with Bus_wen = 1 → dram_we = 0, led = A5A5A5 after the edge; reading FFFFF060 next cycle returns 00A5A5A5. A write of FF000000 leaves led = 000000.
- DRAM path: write DEADBEEF to 00000010 → dram_we = 1, dram_addr = 4, dram_wdata = DEADBEEF in the same cycle. Driving dram_rdata = 12345678 with a read of 00000010 gives Bus_rdata = 12345678 combinationally. An unmapped read at FFFFF004 returns 0 and a write there leaves all peripheral state unchanged.
- Sync latency: sw steps 0 → 123456 → a read of FFFFF070 returns 0 for 1 edge and 00123456 from the 2nd edge on. Same check for button = 5'b10101 → 00000015.
- Scan: SCAN_DIV = 4, tube = 876543F0 → digit 0 shows dig_en FE / seg C0, digit 1 shows FD / 8E, digit 7 shows 7F / 80. Each digit lasts 4 cycles, and the sequence wraps from digit 7 back to FE.
- Reset mid-scan: assert cpu_rst at idx = 5 in the same cycle as a TUBE write → the write is lost, tube read = 0, and dig_en = FF while reset is held. After release, dig_en = FE with seg = C0.
